wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register address width.
REQ-002 Parameter DATA_WIDTH, default 32, datapath width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 i_Stall  input  1  MEM stage not advancing this cycle; WB captures a bubble.
REQ-006 i_Flush  input  1  discard instruction leaving MEM; WB captures a bubble.
REQ-007 i_Valid  input  1  MEM stage holds a real instruction.
REQ-008 i_RdAddr  input  ADDR_WIDTH  destination register.
REQ-009 i_RegWrEn  input  1  instruction writes rd.
REQ-010 i_WbSel  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 illegal.
REQ-011 i_AluResult  input  DATA_WIDTH  ALU result, also the load address.
REQ-012 i_PcPlus4  input  DATA_WIDTH  link value.
REQ-013 i_LoadFunct3  input  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
REQ-014 i_LoadData  input  DATA_WIDTH  raw data-memory word, valid in the cycle the load occupies WB (synchronous RAM).
REQ-015 o_RegWrEn  output  1  register-file write enable.
REQ-016 o_RegWrAddr  output  ADDR_WIDTH  register-file write address.
REQ-017 o_RegWrData  output  DATA_WIDTH  register-file write data.
REQ-018 o_Retire  output  1  one-cycle pulse per retired instruction.
REQ-019 o_Exception  output  1  one-cycle pulse: illegal WbSel, illegal funct3 or misaligned load.
REQ-020 o_InstretCount  output  64  retired-instruction counter.

Function
REQ-021 Each rising edge SHALL load the WB register (valid, rd, wren, wbsel, ALU result, PC+4, funct3) from the MEM inputs; valid SHALL be forced to 0 when i_Stall or i_Flush is high.
REQ-022 Latency SHALL be one cycle from MEM capture to register-file write; all outputs are combinational from the WB register and i_LoadData.
REQ-023 Load formatting SHALL be little-endian using registered ALU result bits [1:0]: LB/LBU byte at [1:0], LH/LHU halfword at bit [1], LW whole word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-024 Misaligned SHALL mean LH/LHU with addr[0]=1 or LW with addr[1:0]!=00; funct3 3, 6, 7 SHALL be illegal only when WbSel=01.
REQ-025 Exception SHALL equal valid AND (WbSel=11 OR (WbSel=01 AND (illegal funct3 OR misaligned))).
REQ-026 o_RegWrEn SHALL equal valid AND wren AND rd!=0 AND NOT exception.
REQ-027 o_RegWrData SHALL be the selected/formatted result when o_RegWrEn=1 and 0 otherwise; o_RegWrAddr SHALL be rd when o_RegWrEn=1 and 0 otherwise.
REQ-028 o_Retire SHALL equal valid AND NOT exception, including instructions with wren=0 or rd=0.
REQ-029 o_InstretCount SHALL increment by 1 on each edge where o_Retire=1, wrapping 2^64-1 to 0.
REQ-030 i_Stall and i_Flush together SHALL produce a single bubble; there is no priority difference.

Reset
REQ-031 Reset SHALL clear all WB-register fields and o_InstretCount to 0, immediately and independent of clk.
REQ-032 During and after reset, until the first valid capture, all outputs SHALL be 0.
REQ-033 Reset asserted while a load occupies WB SHALL drop o_RegWrEn, o_Retire and o_Exception to 0 in the same cycle.

Structure
REQ-034 WbSel encodings, load funct3 codes and counter width SHALL live in the shared light_rv32i defines package.
REQ-035 Load formatting SHALL be a combinational sub-module load_align (inputs word, addr[1:0], funct3; outputs data, misaligned, illegal).

Verification
REQ-036 ALU op rd=5, AluResult=0x1234_5678, WbSel=00 -> next cycle o_RegWrEn=1, addr=5, data=0x1234_5678, o_Retire=1, count 0->1.
REQ-037 LB addr=0x...03, LoadData=0x80FF_0000 -> data=0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr=0x...02 -> 0x0000_80FF.
REQ-038 LW addr=0x...02, rd=7 -> o_Exception=1, o_RegWrEn=0, o_Retire=0, count unchanged.
REQ-039 JAL rd=0, PcPlus4=0x100 -> o_RegWrEn=0, data=0, o_Retire=1.
REQ-040 Valid instruction with i_Flush=1, then with i_Stall=1 -> both captured as bubbles, all outputs 0, count unchanged.
REQ-041 Async reset pulse mid-cycle with a load in WB -> outputs 0 before the next edge, count=0.

Source files
------------

// File: rtl/light_rv32i_pkg.sv
// Shared RV32I definitions for the light_rv32i core: writeback select codes,
// load funct3 codes and the retired-instruction counter width.
package light_rv32i_pkg;

  typedef enum logic [1:0] {
    WB_ALU     = 2'b00,
    WB_LOAD    = 2'b01,
    WB_PC4     = 2'b10,
    WB_ILLEGAL = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam int INSTRET_WIDTH = 64;

endpackage

// File: rtl/load_align.sv
// Little-endian load formatter: lane select plus sign/zero extension, purely combinational.
// Flags misaligned halfword/word accesses and funct3 codes that are not loads.
module load_align
  import light_rv32i_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            addr,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  misaligned,
  output logic                  illegal
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane  = word[{addr, 3'b000} +: 8];
    half_lane  = word[{addr[1], 4'b0000} +: 16];
    data       = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_LB:  data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      F3_LBU: data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      F3_LH: begin
        data       = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
        misaligned = addr[0];
      end
      F3_LHU: begin
        data       = {{(DATA_WIDTH-16){1'b0}}, half_lane};
        misaligned = addr[0];
      end
      F3_LW: begin
        data       = word;
        misaligned = (addr != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one register of MEM results, combinational regfile write/retire/exception.
// One cycle from MEM capture to write; stall or flush captures a bubble, no backpressure upstream.
module wb_stage
  import light_rv32i_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_Stall,
  input  logic                     i_Flush,
  input  logic                     i_Valid,
  input  logic [ADDR_WIDTH-1:0]    i_RdAddr,
  input  logic                     i_RegWrEn,
  input  logic [1:0]               i_WbSel,
  input  logic [DATA_WIDTH-1:0]    i_AluResult,
  input  logic [DATA_WIDTH-1:0]    i_PcPlus4,
  input  logic [2:0]               i_LoadFunct3,
  input  logic [DATA_WIDTH-1:0]    i_LoadData,
  output logic                     o_RegWrEn,
  output logic [ADDR_WIDTH-1:0]    o_RegWrAddr,
  output logic [DATA_WIDTH-1:0]    o_RegWrData,
  output logic                     o_Retire,
  output logic                     o_Exception,
  output logic [INSTRET_WIDTH-1:0] o_InstretCount
);

  localparam logic [INSTRET_WIDTH-1:0] CNT_ONE = {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};

  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic                  wb_wren;
  wb_sel_e               wb_sel;
  logic [DATA_WIDTH-1:0] wb_alu;
  logic [DATA_WIDTH-1:0] wb_pc4;
  logic [2:0]            wb_funct3;

  logic [DATA_WIDTH-1:0]    load_data;
  logic                     load_misaligned;
  logic                     load_illegal;
  logic [DATA_WIDTH-1:0]    result;
  logic                     exception;
  logic                     wr_en;
  logic                     retire;
  logic [INSTRET_WIDTH-1:0] instret;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_wren   <= 1'b0;
      wb_sel    <= WB_ALU;
      wb_alu    <= '0;
      wb_pc4    <= '0;
      wb_funct3 <= '0;
    end else begin
      wb_valid  <= i_Valid & ~i_Stall & ~i_Flush;
      wb_rd     <= i_RdAddr;
      wb_wren   <= i_RegWrEn;
      wb_sel    <= wb_sel_e'(i_WbSel);
      wb_alu    <= i_AluResult;
      wb_pc4    <= i_PcPlus4;
      wb_funct3 <= i_LoadFunct3;
    end
  end

  // The load address is the registered ALU result; memory data arrives in this cycle.
  load_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_align (
    .word       (i_LoadData),
    .addr       (wb_alu[1:0]),
    .funct3     (wb_funct3),
    .data       (load_data),
    .misaligned (load_misaligned),
    .illegal    (load_illegal)
  );

  always_comb begin
    result = wb_alu;
    case (wb_sel)
      WB_LOAD: result = load_data;
      WB_PC4:  result = wb_pc4;
      default: result = wb_alu;
    endcase
  end

  // Load-format faults only matter when the load path is actually selected.
  assign exception = wb_valid & ((wb_sel == WB_ILLEGAL) |
                                 ((wb_sel == WB_LOAD) & (load_illegal | load_misaligned)));
  assign wr_en     = wb_valid & wb_wren & (wb_rd != '0) & ~exception;
  assign retire    = wb_valid & ~exception;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_ONE;
    end
  end

  assign o_RegWrEn      = wr_en;
  assign o_RegWrAddr    = wr_en ? wb_rd : '0;
  assign o_RegWrData    = wr_en ? result : '0;
  assign o_Retire       = retire;
  assign o_Exception    = exception;
  assign o_InstretCount = instret;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, reset corner sequences, then random
// traffic compared against an arithmetic reference of the writeback rules.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_Stall, i_Flush, i_Valid, i_RegWrEn;
  logic [4:0]  i_RdAddr;
  logic [1:0]  i_WbSel;
  logic [31:0] i_AluResult, i_PcPlus4, i_LoadData;
  logic [2:0]  i_LoadFunct3;
  logic        o_RegWrEn, o_Retire, o_Exception;
  logic [4:0]  o_RegWrAddr;
  logic [31:0] o_RegWrData;
  logic [63:0] o_InstretCount;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] model_cnt;

  always #5 clk = ~clk;

  wb_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_Stall        (i_Stall),
    .i_Flush        (i_Flush),
    .i_Valid        (i_Valid),
    .i_RdAddr       (i_RdAddr),
    .i_RegWrEn      (i_RegWrEn),
    .i_WbSel        (i_WbSel),
    .i_AluResult    (i_AluResult),
    .i_PcPlus4      (i_PcPlus4),
    .i_LoadFunct3   (i_LoadFunct3),
    .i_LoadData     (i_LoadData),
    .o_RegWrEn      (o_RegWrEn),
    .o_RegWrAddr    (o_RegWrAddr),
    .o_RegWrData    (o_RegWrData),
    .o_Retire       (o_Retire),
    .o_Exception    (o_Exception),
    .o_InstretCount (o_InstretCount)
  );

  typedef struct packed {
    logic        valid;
    logic        stall;
    logic        flush;
    logic [4:0]  rd;
    logic        wren;
    logic [1:0]  wbsel;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [2:0]  f3;
    logic [31:0] ld;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_ret;
    logic        e_exc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic valid, logic stall, logic flush, logic [4:0] rd,
                              logic wren, logic [1:0] wbsel, logic [31:0] alu,
                              logic [31:0] pc4, logic [2:0] f3, logic [31:0] ld,
                              logic e_we, logic [4:0] e_addr, logic [31:0] e_data,
                              logic e_ret, logic e_exc);
    vec_t v;
    v.valid = valid;  v.stall = stall;   v.flush = flush;   v.rd = rd;
    v.wren = wren;    v.wbsel = wbsel;   v.alu = alu;       v.pc4 = pc4;
    v.f3 = f3;        v.ld = ld;         v.e_we = e_we;     v.e_addr = e_addr;
    v.e_data = e_data; v.e_ret = e_ret;  v.e_exc = e_exc;
    return v;
  endfunction

  // Expected outputs from the architectural rules, using shifts and masks on the word.
  function automatic vec_t ref_model(vec_t v);
    vec_t        r;
    logic [31:0] b, h, res;
    logic [1:0]  a;
    logic        cap, bad, exc;
    r   = v;
    a   = v.alu[1:0];
    b   = (v.ld >> (8 * a)) & 32'h0000_00FF;
    h   = (v.ld >> (16 * (a / 2))) & 32'h0000_FFFF;
    cap = v.valid && !v.stall && !v.flush;
    bad = 1'b0;
    res = 32'h0;
    case (v.wbsel)
      2'd0: res = v.alu;
      2'd2: res = v.pc4;
      2'd1: begin
        case (v.f3)
          3'd0: res = (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
          3'd4: res = b;
          3'd1: begin res = (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h; bad = (a % 2) != 0; end
          3'd5: begin res = h; bad = (a % 2) != 0; end
          3'd2: begin res = v.ld; bad = (a != 2'd0); end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    exc      = cap && bad;
    r.e_exc  = exc;
    r.e_ret  = cap && !exc;
    r.e_we   = cap && v.wren && (v.rd != 5'd0) && !exc;
    r.e_addr = r.e_we ? v.rd : 5'd0;
    r.e_data = r.e_we ? res : 32'h0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".wren"}, {63'b0, o_RegWrEn}, 64'd0);
    chk({tag, ".addr"}, {59'b0, o_RegWrAddr}, 64'd0);
    chk({tag, ".data"}, {32'b0, o_RegWrData}, 64'd0);
    chk({tag, ".retire"}, {63'b0, o_Retire}, 64'd0);
    chk({tag, ".exc"}, {63'b0, o_Exception}, 64'd0);
    chk({tag, ".count"}, o_InstretCount, 64'd0);
  endtask

  task automatic apply(input vec_t v, input string tag);
    i_Valid      = v.valid;
    i_Stall      = v.stall;
    i_Flush      = v.flush;
    i_RdAddr     = v.rd;
    i_RegWrEn    = v.wren;
    i_WbSel      = v.wbsel;
    i_AluResult  = v.alu;
    i_PcPlus4    = v.pc4;
    i_LoadFunct3 = v.f3;
    i_LoadData   = ~v.ld;
    @(posedge clk);
    #1;
    i_LoadData = v.ld;
    #1;
    chk({tag, ".wren"}, {63'b0, o_RegWrEn}, {63'b0, v.e_we});
    chk({tag, ".addr"}, {59'b0, o_RegWrAddr}, {59'b0, v.e_addr});
    chk({tag, ".data"}, {32'b0, o_RegWrData}, {32'b0, v.e_data});
    chk({tag, ".retire"}, {63'b0, o_Retire}, {63'b0, v.e_ret});
    chk({tag, ".exc"}, {63'b0, o_Exception}, {63'b0, v.e_exc});
    chk({tag, ".count"}, o_InstretCount, model_cnt);
    if (v.e_ret) model_cnt = model_cnt + 64'd1;
  endtask

  task automatic idle_inputs();
    i_Valid = 1'b0; i_Stall = 1'b0; i_Flush = 1'b0; i_RdAddr = 5'd0;
    i_RegWrEn = 1'b0; i_WbSel = 2'd0; i_AluResult = 32'h0; i_PcPlus4 = 32'h0;
    i_LoadFunct3 = 3'd0; i_LoadData = 32'h0;
  endtask

  initial begin
    vec_t v;
    model_cnt = 64'd0;

    //        vld stl fls rd     wr   sel    alu           pc4           f3    ld            we   addr   data          ret  exc
    tbl.push_back(mk(1'b1,1'b0,1'b0,5'd5, 1'b1,2'd0,32'h1234_5678,32'h0000_0000,3'd0,32'h0000_0000,1'b1,5'd5, 32'h1234_5678,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,5'd8, 1'b1,2'd1,32'h0000_0103,32'h0000_0000,3'd0,32'h80FF_0000,1'b1,5'd8, 32'hFFFF_FF80,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,5'd8, 1'b1,2'd1,32'h0000_0103,32'h0000_0000,3'd4,32'h80FF_0000,1'b1,5'd8, 32'h0000_0080,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,5'd9, 1'b1,2'd1,32'h0000_0102,32'h0000_0000,3'd5,32'h80FF_0000,1'b1,5'd9, 32'h0000_80FF,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,5'd9, 1'b1,2'd1,32'h0000_0102,32'h0000_0000,3'd1,32'h80FF_0000,1'b1,5'd9, 32'hFFFF_80FF,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,5'd7, 1'b1,2'd1,32'h0000_0102,32'h0000_0000,3'd2,32'hAABB_CCDD,1'b0,5'd0, 32'h0000_0000,1'b0,1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,5'd0, 1'b1,2'd2,32'h0000_0040,32'h0000_0100,3'd0,32'h0000_0000,1'b0,5'd0, 32'h0000_0000,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b1,5'd4, 1'b1,2'd0,32'h0000_1111,32'h0000_0000,3'd0,32'h0000_0000,1'b0,5'd0, 32'h0000_0000,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b0,5'd4, 1'b1,2'd0,32'h0000_2222,32'h0000_0000,3'd0,32'h0000_0000,1'b0,5'd0, 32'h0000_0000,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b1,5'd4, 1'b1,2'd3,32'h0000_3333,32'h0000_0000,3'd0,32'h0000_0000,1'b0,5'd0, 32'h0000_0000,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,5'd6, 1'b1,2'd3,32'h0000_4444,32'h0000_0000,3'd0,32'h0000_0000,1'b0,5'd0, 32'h0000_0000,1'b0,1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,5'd6, 1'b1,2'd1,32'h0000_0000,32'h0000_0000,3'd3,32'h1234_5678,1'b0,5'd0, 32'h0000_0000,1'b0,1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,5'd6, 1'b1,2'd0,32'h0000_5555,32'h0000_0000,3'd3,32'h0000_0000,1'b1,5'd6, 32'h0000_5555,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,5'd3, 1'b0,2'd0,32'h0000_6666,32'h0000_0000,3'd0,32'h0000_0000,1'b0,5'd0, 32'h0000_0000,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,5'd31,1'b1,2'd1,32'h0000_0100,32'h0000_0000,3'd2,32'hDEAD_BEEF,1'b1,5'd31,32'hDEAD_BEEF,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,5'd2, 1'b1,2'd1,32'h0000_0101,32'h0000_0000,3'd1,32'hDEAD_BEEF,1'b0,5'd0, 32'h0000_0000,1'b0,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,5'd2, 1'b1,2'd3,32'h0000_0101,32'h0000_0000,3'd7,32'hDEAD_BEEF,1'b0,5'd0, 32'h0000_0000,1'b0,1'b0));

    // Reset state, both while asserted and after release before any capture.
    idle_inputs();
    reset = 1'b1;
    #3;
    chk_zero("in_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_zero("post_reset");

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Async reset mid-cycle while a good load is retiring.
    v = mk(1'b1,1'b0,1'b0,5'd3,1'b1,2'd1,32'h0000_0040,32'h0,3'd2,32'hCAFE_F00D,
           1'b1,5'd3,32'hCAFE_F00D,1'b1,1'b0);
    apply(v, "pre_rst_load");
    idle_inputs();
    i_LoadData = 32'hCAFE_F00D;
    #2 reset = 1'b1;
    #1;
    chk_zero("rst_load");
    #1 reset = 1'b0;
    model_cnt = 64'd0;

    // Async reset mid-cycle while a misaligned load is raising an exception.
    v = mk(1'b1,1'b0,1'b0,5'd3,1'b1,2'd1,32'h0000_0043,32'h0,3'd5,32'h1111_2222,
           1'b0,5'd0,32'h0,1'b0,1'b1);
    apply(v, "pre_rst_exc");
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    chk_zero("rst_exc");
    #1 reset = 1'b0;
    model_cnt = 64'd0;

    for (int i = 0; i < 400; i++) begin
      v.valid = ($urandom_range(0, 7) != 0);
      v.stall = ($urandom_range(0, 7) == 0);
      v.flush = ($urandom_range(0, 7) == 0);
      v.rd    = 5'($urandom_range(0, 31));
      v.wren  = ($urandom_range(0, 3) != 0);
      v.wbsel = 2'($urandom_range(0, 3));
      v.alu   = $urandom;
      v.pc4   = $urandom;
      v.f3    = 3'($urandom_range(0, 7));
      v.ld    = $urandom;
      apply(ref_model(v), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
